// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: multi-cycle WIDTH-bit adder, BITS_PER_CYCLE bits per clock, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_fsm #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;

    if (WIDTH % BPC != 0) begin : g_bad_bpc
        $error("serial_adder_fsm: BITS_PER_CYCLE must divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] part;
    logic             carry;
    logic [CW-1:0]    count;
    logic [BPC:0]     slice;
    logic [WIDTH-1:0] part_next;
    logic             last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             msb_cin;
`endif

    // Slice adder; the new slice enters the partial result from the MSB side
    always_comb begin
        slice     = {1'b0, a_sr[BPC-1:0]} + {1'b0, b_sr[BPC-1:0]} + {{BPC{1'b0}}, carry};
        part_next = WIDTH'({slice[BPC-1:0], part} >> BPC);
        last      = count == CW'(STEPS - 1);
`ifdef SERIAL_ADDER_OVF_EN
        msb_cin   = slice[BPC-1] ^ a_sr[BPC-1] ^ b_sr[BPC-1];
`endif
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            count <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            part  <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        count <= '0;
                        part  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> BPC;
                    b_sr  <= b_sr >> BPC;
                    carry <= slice[BPC];
                    part  <= part_next;
                    count <= count + 1'b1;
                    if (last) begin
                        sum   <= part_next;
                        cout  <= slice[BPC];
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= msb_cin ^ slice[BPC];
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
